// File: rtl/ast_pkg.sv
// Shared types and constants for the asteroid hit manager: slot life states,
// score limits and the saturating BCD increment used by the scorer.
package ast_pkg;

  typedef enum logic [1:0] {
    S_ALIVE,
    S_EXPLODE,
    S_DEAD
  } slot_state_t;

  localparam int          N_AST        = 8;
  localparam logic [15:0] SCORE_MAX    = 16'h9999;
  localparam int          COMBO_FRAMES = 30;

  // Add one to a 4-digit BCD value, rippling the carry digit by digit and
  // sticking at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc1(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ast_slot.sv
// One asteroid slot: ALIVE -> EXPLODE -> DEAD -> ALIVE life cycle, with a
// frame counter timing the explosion and the respawn delay.
import ast_pkg::*;

module ast_slot #(
  parameter int EXPL_FRAMES    = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic hit,
  input  logic tick,
  input  logic active,
  output logic alive,
  output logic explode
);

  slot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_ALIVE: begin
        if (hit && active) begin
          state_d = S_EXPLODE;
          cnt_d   = CNT_W'(EXPL_FRAMES - 1);
        end
      end
      S_EXPLODE: begin
        if (tick && active) begin
          if (cnt_q == '0) begin
            state_d = S_DEAD;
            cnt_d   = CNT_W'(RESPAWN_FRAMES - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DEAD: begin
        if (tick && active) begin
          if (cnt_q == '0) state_d = S_ALIVE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = S_ALIVE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_ALIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded straight from the state flops, so no input reaches these outputs.
  assign alive   = (state_q == S_ALIVE);
  assign explode = (state_q == S_EXPLODE);

endmodule

// File: rtl/ast_hit_manager.sv
// Asteroid hit manager: decodes the hit index, runs eight slot FSMs and keeps
// a saturating BCD score. Define COMBO_SCORE_EN for the double-score combo window.
import ast_pkg::*;

module ast_hit_manager #(
  parameter int EXPL_FRAMES    = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  which,
  input  logic        frame_tick,
  input  logic        game_active,
  output logic [7:0]  alive,
  output logic [7:0]  explode,
  output logic [15:0] score,
  output logic        hit_pulse
);

  logic [N_AST-1:0] hit_vec;
  logic [2:0]       hit_idx;
  logic             accept;
  logic [15:0]      score_next;

  assign hit_idx = 3'(which - 4'd1);

  always_comb begin
    hit_vec = '0;
    if (which >= 4'd1 && which <= 4'd8) hit_vec[hit_idx] = 1'b1;
  end

  // A hit counts only on a slot that is still ALIVE; a held index hits once.
  assign accept = game_active && |(hit_vec & alive);

  for (genvar i = 0; i < N_AST; i++) begin : g_slot
    ast_slot #(
      .EXPL_FRAMES   (EXPL_FRAMES),
      .RESPAWN_FRAMES(RESPAWN_FRAMES),
      .CNT_W         (CNT_W)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .hit    (hit_vec[i]),
      .tick   (frame_tick),
      .active (game_active),
      .alive  (alive[i]),
      .explode(explode[i])
    );
  end

`ifdef COMBO_SCORE_EN
  logic [4:0] combo_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      combo_q <= '0;
    end else if (accept) begin
      combo_q <= 5'(COMBO_FRAMES);
    end else if (frame_tick && game_active && combo_q != '0) begin
      combo_q <= combo_q - 1'b1;
    end
  end

  assign score_next = (combo_q != '0) ? bcd_inc1(bcd_inc1(score)) : bcd_inc1(score);
`else
  assign score_next = bcd_inc1(score);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      score     <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= accept;
      if (accept) score <= score_next;
    end
  end

endmodule

// File: tb/tb_ast_hit_manager.sv
// Directed self-checking bench for ast_hit_manager: a default-parameter
// instance for behaviour and a short-timer instance for score saturation.
module tb_ast_hit_manager;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  which;
  logic        frame_tick, game_active;
  logic [7:0]  alive, explode;
  logic [15:0] score;
  logic        hit_pulse;

  logic [3:0]  which_f;
  logic        tick_f, active_f;
  logic [7:0]  alive_f, explode_f;
  logic [15:0] score_f;
  logic        hit_pulse_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ast_hit_manager #(.EXPL_FRAMES(8), .RESPAWN_FRAMES(60), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .which(which), .frame_tick(frame_tick),
    .game_active(game_active), .alive(alive), .explode(explode),
    .score(score), .hit_pulse(hit_pulse)
  );

  ast_hit_manager #(.EXPL_FRAMES(1), .RESPAWN_FRAMES(1), .CNT_W(8)) dut_fast (
    .clk(clk), .resetn(resetn), .which(which_f), .frame_tick(tick_f),
    .game_active(active_f), .alive(alive_f), .explode(explode_f),
    .score(score_f), .hit_pulse(hit_pulse_f)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    which = 4'd0; frame_tick = 1'b0; game_active = 1'b1;
    which_f = 4'd0; tick_f = 1'b0; active_f = 1'b1;
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (alive !== 8'hFF) begin failures++; $display("FAIL reset_alive: got %h want ff", alive); end
    checks++; if (explode !== 8'h00) begin failures++; $display("FAIL reset_explode: got %h want 00", explode); end
    checks++; if (score !== 16'h0000) begin failures++; $display("FAIL reset_score: got %h want 0000", score); end
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b want 0", hit_pulse); end
  endtask

  task automatic test_single_hit();
    do_reset();
    which = 4'd3;
    cyc();
    which = 4'd0;
    checks++; if (alive !== 8'hFB) begin failures++; $display("FAIL hit3_alive: got %h want fb", alive); end
    checks++; if (explode !== 8'h04) begin failures++; $display("FAIL hit3_explode: got %h want 04", explode); end
    checks++; if (score !== 16'h0001) begin failures++; $display("FAIL hit3_score: got %h want 0001", score); end
    checks++; if (hit_pulse !== 1'b1) begin failures++; $display("FAIL hit3_pulse: got %b want 1", hit_pulse); end
    cyc();
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit3_pulse_end: got %b want 0", hit_pulse); end
  endtask

  task automatic test_held_hit();
    int pulses;
    do_reset();
    pulses = 0;
    which = 4'd5;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (hit_pulse) pulses++;
    end
    which = 4'd0;
    cyc();
    if (hit_pulse) pulses++;
    checks++; if (score !== 16'h0001) begin failures++; $display("FAIL held_score: got %h want 0001", score); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL held_pulses: got %0d want 1", pulses); end
    checks++; if (explode !== 8'h10) begin failures++; $display("FAIL held_explode: got %h want 10", explode); end
  endtask

  task automatic test_life_cycle();
    do_reset();
    which = 4'd1;
    cyc();
    which = 4'd0;
    ticks(7);
    checks++; if (explode !== 8'h01) begin failures++; $display("FAIL expl_7ticks: got %h want 01", explode); end
    ticks(1);
    checks++; if (explode !== 8'h00) begin failures++; $display("FAIL expl_8ticks: got %h want 00", explode); end
    checks++; if (alive !== 8'hFE) begin failures++; $display("FAIL dead_alive: got %h want fe", alive); end
    which = 4'd1;
    cyc();
    which = 4'd0;
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL dead_hit_pulse: got %b want 0", hit_pulse); end
    checks++; if (score !== 16'h0001) begin failures++; $display("FAIL dead_hit_score: got %h want 0001", score); end
    ticks(59);
    checks++; if (alive !== 8'hFE) begin failures++; $display("FAIL dead_59ticks: got %h want fe", alive); end
    ticks(1);
    checks++; if (alive !== 8'hFF) begin failures++; $display("FAIL respawn_60ticks: got %h want ff", alive); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    which = 4'd2; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    checks++; if (explode !== 8'h02) begin failures++; $display("FAIL b2b_first_explode: got %h want 02", explode); end
    which = 4'd3;
    cyc();
    which = 4'd0;
    checks++; if (explode !== 8'h06) begin failures++; $display("FAIL b2b_second_explode: got %h want 06", explode); end
    checks++; if (score !== 16'h0002) begin failures++; $display("FAIL b2b_score: got %h want 0002", score); end
    checks++; if (hit_pulse !== 1'b1) begin failures++; $display("FAIL b2b_pulse: got %b want 1", hit_pulse); end
    ticks(7);
    checks++; if (explode !== 8'h06) begin failures++; $display("FAIL b2b_7ticks: got %h want 06", explode); end
    ticks(1);
    checks++; if (explode !== 8'h00) begin failures++; $display("FAIL b2b_8ticks: got %h want 00", explode); end
  endtask

  task automatic test_ignored();
    do_reset();
    which = 4'd4;
    cyc();
    which = 4'd12;
    cyc();
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL idx12_pulse: got %b want 0", hit_pulse); end
    which = 4'd0;
    cyc();
    which = 4'd15;
    cyc();
    checks++; if ({alive, explode, score} !== {8'hF7, 8'h08, 16'h0001}) begin
      failures++; $display("FAIL invalid_idx_state: got %h/%h/%h want f7/08/0001", alive, explode, score);
    end
    game_active = 1'b0; which = 4'd2;
    ticks(10);
    checks++; if ({alive, explode, score} !== {8'hF7, 8'h08, 16'h0001}) begin
      failures++; $display("FAIL inactive_state: got %h/%h/%h want f7/08/0001", alive, explode, score);
    end
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL inactive_pulse: got %b want 0", hit_pulse); end
    game_active = 1'b1; which = 4'd0;
    ticks(7);
    checks++; if (explode !== 8'h08) begin failures++; $display("FAIL resume_7ticks: got %h want 08", explode); end
    ticks(1);
    checks++; if (explode !== 8'h00) begin failures++; $display("FAIL resume_8ticks: got %h want 00", explode); end
  endtask

  task automatic test_saturation();
    int model, pulses, inc;
    do_reset();
    model = 0; pulses = 0;
    tick_f = 1'b1;
    for (int i = 0; i < 9999; i++) begin
      which_f = 4'((i % 8) + 1);
      cyc();
      if (hit_pulse_f) pulses++;
`ifdef COMBO_SCORE_EN
      inc = (i == 0) ? 1 : 2;
`else
      inc = 1;
`endif
      model = (model + inc > 9999) ? 9999 : model + inc;
      if (i + 1 == 9 || i + 1 == 10 || i + 1 == 100 || i + 1 == 1000 || i + 1 == 5555) begin
        checks++; if (score_f !== to_bcd(model)) begin
          failures++; $display("FAIL sat_progress_%0d: got %h want %h", i + 1, score_f, to_bcd(model));
        end
      end
    end
    checks++; if (score_f !== 16'h9999) begin failures++; $display("FAIL sat_9999: got %h want 9999", score_f); end
    checks++; if (pulses != 9999) begin failures++; $display("FAIL sat_pulses: got %0d want 9999", pulses); end
    which_f = 4'((9999 % 8) + 1);
    cyc();
    which_f = 4'd0; tick_f = 1'b0;
    checks++; if (score_f !== 16'h9999) begin failures++; $display("FAIL sat_hold: got %h want 9999", score_f); end
    checks++; if (hit_pulse_f !== 1'b1) begin failures++; $display("FAIL sat_pulse: got %b want 1", hit_pulse_f); end
  endtask

`ifdef COMBO_SCORE_EN
  task automatic test_combo();
    do_reset();
    which = 4'd1;
    cyc();
    which = 4'd0;
    ticks(10);
    which = 4'd2;
    cyc();
    which = 4'd0;
    checks++; if (score !== 16'h0003) begin failures++; $display("FAIL combo_score: got %h want 0003", score); end
    ticks(40);
    which = 4'd3;
    cyc();
    which = 4'd0;
    checks++; if (score !== 16'h0004) begin failures++; $display("FAIL combo_expired: got %h want 0004", score); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_held_hit();
    test_life_cycle();
    test_back_to_back();
    test_ignored();
    test_saturation();
`ifdef COMBO_SCORE_EN
    test_combo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
